mem_stage_sequencer: RTL and testbench

- Sequences all instruction-fetch and data-memory traffic for the processor. It sits between the datapath/control unit and the memory interface wrapper.
- Drives the ROM fetch port (address, clock enable) and captures the instruction.
- Drives the RAM port (address, read/write, enable, write data) for a fixed latency and captures load data.
- Returns a one-cycle completion pulse per request to the control unit.

---
 rtl/mem_stage_sequencer.sv | 109 ++++++++++
 tb/tb_mem_stage_sequencer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mem_stage_sequencer.sv
// Sequences ROM instruction fetches and fixed-latency RAM loads/stores for the datapath.
// Every output is registered; one request is serviced at a time and only accepted while idle.
module mem_stage_sequencer #(
  parameter int unsigned RAM_LATENCY = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Fetch_Req,
  input  logic [31:0] PC_In,
  input  logic        Mem_Req,
  input  logic        Mem_Write,
  input  logic [31:0] Addr_In,
  input  logic [31:0] Store_Data,
  output logic [31:0] ROM_Address,
  output logic        ROM_Read,
  input  logic [31:0] ROM_Data_Out,
  output logic [31:0] RAM_Address,
  output logic        RAM_Read_H_Write_L,
  output logic        RAM_Enable,
  output logic [31:0] RAM_Data_In,
  input  logic [31:0] RAM_Data_Out,
  output logic [31:0] Instr_Out,
  output logic [31:0] Load_Data,
  output logic        Busy,
  output logic        Fetch_Done,
  output logic        Mem_Done
);

  typedef enum logic [2:0] {
    IDLE, FETCH, FETCH_CAP, MEM_ACCESS, DONE_F, DONE_M
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(RAM_LATENCY - 1);

  state_t     state, next_state;
  logic [3:0] cnt;
  logic       mem_write;

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  // Mem_Req has priority over Fetch_Req when both arrive together.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (Mem_Req)        next_state = MEM_ACCESS;
        else if (Fetch_Req) next_state = FETCH;
      end
      FETCH:      next_state = FETCH_CAP;
      FETCH_CAP:  next_state = DONE_F;
      MEM_ACCESS: if (cnt == 4'd0) next_state = DONE_M;
      DONE_F:     next_state = IDLE;
      DONE_M:     next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  // Strobes are decoded from next_state so they line up with the state they belong to.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ROM_Address        <= '0;
      ROM_Read           <= 1'b0;
      RAM_Address        <= '0;
      RAM_Read_H_Write_L <= 1'b1;
      RAM_Enable         <= 1'b0;
      RAM_Data_In        <= '0;
      Instr_Out          <= '0;
      Load_Data          <= '0;
      Busy               <= 1'b0;
      Fetch_Done         <= 1'b0;
      Mem_Done           <= 1'b0;
      cnt                <= '0;
      mem_write          <= 1'b0;
    end else begin
      ROM_Read   <= (next_state == FETCH);
      RAM_Enable <= (next_state == MEM_ACCESS);
      Fetch_Done <= (next_state == DONE_F);
      Mem_Done   <= (next_state == DONE_M);
      Busy       <= (next_state != IDLE);
      case (state)
        IDLE: begin
          if (Mem_Req) begin
            RAM_Address        <= Addr_In;
            RAM_Data_In        <= Store_Data;
            RAM_Read_H_Write_L <= ~Mem_Write;
            mem_write          <= Mem_Write;
            cnt                <= CNT_INIT;
          end else if (Fetch_Req) begin
            ROM_Address <= PC_In;
          end
        end
        FETCH_CAP: Instr_Out <= ROM_Data_Out;
        MEM_ACCESS: begin
          if (cnt == 4'd0) begin
            RAM_Read_H_Write_L <= 1'b1;
            if (!mem_write) Load_Data <= RAM_Data_Out;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_sequencer.sv
// Directed bench for mem_stage_sequencer with hand-computed cycle-by-cycle expectations.
module tb_mem_stage_sequencer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Fetch_Req, Mem_Req, Mem_Write;
  logic [31:0] PC_In, Addr_In, Store_Data, ROM_Data_Out, RAM_Data_Out;
  logic [31:0] ROM_Address, RAM_Address, RAM_Data_In, Instr_Out, Load_Data;
  logic        ROM_Read, RAM_Read_H_Write_L, RAM_Enable, Busy, Fetch_Done, Mem_Done;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_a, cnt_b;

  mem_stage_sequencer #(.RAM_LATENCY(2)) dut (
    .Clock(Clock), .Reset(Reset),
    .Fetch_Req(Fetch_Req), .PC_In(PC_In),
    .Mem_Req(Mem_Req), .Mem_Write(Mem_Write), .Addr_In(Addr_In), .Store_Data(Store_Data),
    .ROM_Address(ROM_Address), .ROM_Read(ROM_Read), .ROM_Data_Out(ROM_Data_Out),
    .RAM_Address(RAM_Address), .RAM_Read_H_Write_L(RAM_Read_H_Write_L),
    .RAM_Enable(RAM_Enable), .RAM_Data_In(RAM_Data_In), .RAM_Data_Out(RAM_Data_Out),
    .Instr_Out(Instr_Out), .Load_Data(Load_Data), .Busy(Busy),
    .Fetch_Done(Fetch_Done), .Mem_Done(Mem_Done)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    Reset = 1'b1; Fetch_Req = 0; Mem_Req = 0; Mem_Write = 0;
    PC_In = '0; Addr_In = '0; Store_Data = '0; ROM_Data_Out = '0; RAM_Data_Out = '0;
    step(); step();
    check("rst_rom_read", 32'(ROM_Read), 0);
    check("rst_ram_en", 32'(RAM_Enable), 0);
    check("rst_rw", 32'(RAM_Read_H_Write_L), 1);
    check("rst_busy", 32'(Busy), 0);
    check("rst_done", {30'd0, Fetch_Done, Mem_Done}, 0);
    check("rst_instr", Instr_Out, 0);
    check("rst_load", Load_Data, 0);
    check("rst_addr", ROM_Address | RAM_Address | RAM_Data_In, 0);

    // 1: fetch at PC=4
    Reset = 0; Fetch_Req = 1; PC_In = 32'h4; ROM_Data_Out = 32'hDEADBEEF;
    step(); Fetch_Req = 0;
    check("f1_rom_read", 32'(ROM_Read), 1);
    check("f1_rom_addr", ROM_Address, 32'h4);
    check("f1_busy", 32'(Busy), 1);
    step();
    check("f2_rom_read", 32'(ROM_Read), 0);
    check("f2_done", 32'(Fetch_Done), 0);
    step();
    check("f3_done", 32'(Fetch_Done), 1);
    check("f3_instr", Instr_Out, 32'hDEADBEEF);
    step();
    check("f4_done", 32'(Fetch_Done), 0);
    check("f4_busy", 32'(Busy), 0);

    // 2: load at 0x10
    Mem_Req = 1; Mem_Write = 0; Addr_In = 32'h10; RAM_Data_Out = 32'h12345678;
    step(); Mem_Req = 0;
    check("ld1_en", 32'(RAM_Enable), 1);
    check("ld1_rw", 32'(RAM_Read_H_Write_L), 1);
    check("ld1_addr", RAM_Address, 32'h10);
    step();
    check("ld2_en", 32'(RAM_Enable), 1);
    check("ld2_done", 32'(Mem_Done), 0);
    step();
    check("ld3_en", 32'(RAM_Enable), 0);
    check("ld3_done", 32'(Mem_Done), 1);
    check("ld3_data", Load_Data, 32'h12345678);
    step();
    check("ld4_done", 32'(Mem_Done), 0);
    check("ld4_busy", 32'(Busy), 0);

    // 3: store at 0x20
    Mem_Req = 1; Mem_Write = 1; Addr_In = 32'h20; Store_Data = 32'hA5A5A5A5;
    RAM_Data_Out = 32'h0BADF00D;
    step(); Mem_Req = 0; Mem_Write = 0;
    check("st1_rw", 32'(RAM_Read_H_Write_L), 0);
    check("st1_din", RAM_Data_In, 32'hA5A5A5A5);
    check("st1_addr", RAM_Address, 32'h20);
    step();
    check("st2_rw", 32'(RAM_Read_H_Write_L), 0);
    check("st2_en", 32'(RAM_Enable), 1);
    step();
    check("st3_rw", 32'(RAM_Read_H_Write_L), 1);
    check("st3_done", 32'(Mem_Done), 1);
    check("st3_load_hold", Load_Data, 32'h12345678);
    step();

    // 4: simultaneous requests, memory wins; fetch re-asserted at max address
    Mem_Req = 1; Fetch_Req = 1; Addr_In = 32'h30; RAM_Data_Out = 32'h00000055;
    step(); Mem_Req = 0; Fetch_Req = 0;
    cnt_a = 32'(ROM_Read);
    step(); cnt_a += 32'(ROM_Read);
    step(); cnt_a += 32'(ROM_Read);
    check("both_no_fetch", cnt_a, 0);
    check("both_mem_done", 32'(Mem_Done), 1);
    check("both_load", Load_Data, 32'h00000055);
    step();
    Fetch_Req = 1; PC_In = 32'hFFFFFFFF; ROM_Data_Out = 32'hCAFEF00D;
    step(); Fetch_Req = 0;
    check("refetch_addr", ROM_Address, 32'hFFFFFFFF);
    step(); step();
    check("refetch_done", 32'(Fetch_Done), 1);
    check("refetch_instr", Instr_Out, 32'hCAFEF00D);
    step();

    // 5: reset in the second store access cycle
    Mem_Req = 1; Mem_Write = 1; Addr_In = 32'h40; Store_Data = 32'h11112222;
    step(); Mem_Req = 0; Mem_Write = 0;
    step(); Reset = 1;
    step(); Reset = 0;
    check("rst_mid_en", 32'(RAM_Enable), 0);
    check("rst_mid_rw", 32'(RAM_Read_H_Write_L), 1);
    check("rst_mid_busy", 32'(Busy), 0);
    cnt_a = 32'(Mem_Done);
    step(); cnt_a += 32'(Mem_Done);
    step(); cnt_a += 32'(Mem_Done);
    check("rst_mid_no_done", cnt_a, 0);
    check("rst_mid_instr", Instr_Out, 0);

    // 6: Mem_Req pulse while a fetch is in flight is ignored
    Fetch_Req = 1; PC_In = 32'h100; ROM_Data_Out = 32'h76543210;
    step(); Fetch_Req = 0; Mem_Req = 1; Mem_Write = 0; Addr_In = 32'h200;
    cnt_a = 32'(RAM_Enable); cnt_b = 32'(Fetch_Done);
    step(); Mem_Req = 0;
    for (int i = 0; i < 5; i++) begin
      cnt_a += 32'(RAM_Enable);
      cnt_b += 32'(Fetch_Done);
      step();
    end
    check("busy_no_ram", cnt_a, 0);
    check("busy_one_done", cnt_b, 1);
    check("busy_instr", Instr_Out, 32'h76543210);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
